// File: rtl/branch_resolve_queue_if.sv
// Bundle of the allocate, resolve, predictor-update and redirect signals
// that pass between decode/execute and the branch resolve queue.
interface branch_resolve_queue_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  flush_i;
   logic                  alloc_valid_i;
   logic                  alloc_ready_o;
   logic [ADDR_WIDTH-1:0] alloc_pc_i;
   logic                  alloc_pred_taken_i;
   logic [ADDR_WIDTH-1:0] alloc_pred_target_i;
   logic                  resolve_valid_i;
   logic                  resolve_taken_i;
   logic [ADDR_WIDTH-1:0] resolve_target_i;
   logic                  update_o;
   logic [ADDR_WIDTH-1:0] update_pc_o;
   logic                  actual_taken_o;
   logic [ADDR_WIDTH-1:0] actual_target_o;
   logic                  is_branch_o;
   logic                  mispredict_o;
   logic [ADDR_WIDTH-1:0] redirect_pc_o;
   logic                  underflow_o;
   logic [31:0]           branch_count_o;
   logic [31:0]           mispredict_count_o;

   // The queue itself sees the bus from this side
   modport slave (
      input  flush_i, alloc_valid_i, alloc_pc_i, alloc_pred_taken_i, alloc_pred_target_i,
      input  resolve_valid_i, resolve_taken_i, resolve_target_i,
      output alloc_ready_o, update_o, update_pc_o, actual_taken_o, actual_target_o,
      output is_branch_o, mispredict_o, redirect_pc_o, underflow_o,
      output branch_count_o, mispredict_count_o
   );

   // Pipeline / test driver side
   modport master (
      output flush_i, alloc_valid_i, alloc_pc_i, alloc_pred_taken_i, alloc_pred_target_i,
      output resolve_valid_i, resolve_taken_i, resolve_target_i,
      input  alloc_ready_o, update_o, update_pc_o, actual_taken_o, actual_target_o,
      input  is_branch_o, mispredict_o, redirect_pc_o, underflow_o,
      input  branch_count_o, mispredict_count_o
   );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight control-flow instructions. Holds each
// prediction until execute resolves it, then emits the predictor update
// packet and, on a wrong prediction, a front-end redirect that also squashes
// every younger entry.
module branch_resolve_queue #(
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = 32
) (
   input logic                    clk_i,
   input logic                    rst_i,
   branch_resolve_queue_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [ADDR_WIDTH-1:0] r_pcMem         [DEPTH];
   logic                  r_predTakenMem  [DEPTH];
   logic [ADDR_WIDTH-1:0] r_predTargetMem [DEPTH];

   logic [PW-1:0]         r_head;
   logic [PW-1:0]         r_tail;
   logic [CW-1:0]         r_count;

   logic                  r_update;
   logic [ADDR_WIDTH-1:0] r_updatePc;
   logic                  r_actualTaken;
   logic [ADDR_WIDTH-1:0] r_actualTarget;
   logic                  r_mispredict;
   logic [ADDR_WIDTH-1:0] r_redirectPc;
   logic                  r_underflow;
   logic [31:0]           r_branchCount;
   logic [31:0]           r_mispredictCount;

   logic                  w_full;
   logic                  w_push;
   logic                  w_resolve;
   logic [ADDR_WIDTH-1:0] w_headPc;
   logic                  w_headPredTaken;
   logic [ADDR_WIDTH-1:0] w_headPredTarget;
   logic                  w_mispredict;
   logic                  w_squash;
   logic [ADDR_WIDTH-1:0] w_nextPc;

   // Readiness comes from registered occupancy only, so a pop in the same
   // cycle never opens a slot for a push.
   assign w_full    = (r_count == FULL_COUNT);
   assign w_push    = bus.alloc_valid_i && !w_full;
   assign w_resolve = bus.resolve_valid_i && (r_count != '0);

   assign w_headPc         = r_pcMem[r_head];
   assign w_headPredTaken  = r_predTakenMem[r_head];
   assign w_headPredTarget = r_predTargetMem[r_head];

   // A target only matters for a taken branch; a not-taken branch is wrong
   // only if its direction was wrong.
   assign w_mispredict = w_resolve &&
                         ((w_headPredTaken != bus.resolve_taken_i) ||
                          (bus.resolve_taken_i && (w_headPredTarget != bus.resolve_target_i)));

   // Both a trap flush and a mispredict empty the queue and drop any push.
   assign w_squash = bus.flush_i || w_mispredict;

   assign w_nextPc = bus.resolve_taken_i ? bus.resolve_target_i
                                         : (w_headPc + ADDR_WIDTH'(4));

   // Entry storage is plain data behind the pointers, so it needs no reset.
   always_ff @(posedge clk_i) begin
      if (!rst_i && w_push && !w_squash) begin
         r_pcMem[r_tail]         <= bus.alloc_pc_i;
         r_predTakenMem[r_tail]  <= bus.alloc_pred_taken_i;
         r_predTargetMem[r_tail] <= bus.alloc_pred_target_i;
      end
   end

   // Head/tail/occupancy bookkeeping; a squash resets everything to empty.
   always_ff @(posedge clk_i) begin
      if (rst_i || w_squash) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + PW'(1);
         end
         if (w_resolve) begin
            r_head <= r_head + PW'(1);
         end
         if (w_push && !w_resolve) begin
            r_count <= r_count + CW'(1);
         end else if (!w_push && w_resolve) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   // Registered update/redirect packet; payload holds between resolves and the
   // redirect is withheld when a trap flush owns the front end.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_update       <= 1'b0;
         r_updatePc     <= '0;
         r_actualTaken  <= 1'b0;
         r_actualTarget <= '0;
         r_mispredict   <= 1'b0;
         r_redirectPc   <= '0;
      end else begin
         r_update     <= w_resolve;
         r_mispredict <= w_mispredict && !bus.flush_i;
         if (w_resolve) begin
            r_updatePc     <= w_headPc;
            r_actualTaken  <= bus.resolve_taken_i;
            r_actualTarget <= bus.resolve_target_i;
            r_redirectPc   <= w_nextPc;
         end
      end
   end

   // Statistics: saturating counters and a sticky flag for resolves that
   // arrived with nothing tracked.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_underflow       <= 1'b0;
         r_branchCount     <= '0;
         r_mispredictCount <= '0;
      end else begin
         if (bus.resolve_valid_i && (r_count == '0)) begin
            r_underflow <= 1'b1;
         end
         if (w_resolve && (r_branchCount != 32'hFFFF_FFFF)) begin
            r_branchCount <= r_branchCount + 32'd1;
         end
         if (w_mispredict && (r_mispredictCount != 32'hFFFF_FFFF)) begin
            r_mispredictCount <= r_mispredictCount + 32'd1;
         end
      end
   end

   assign bus.alloc_ready_o      = !w_full;
   assign bus.update_o           = r_update;
   assign bus.is_branch_o        = r_update;
   assign bus.update_pc_o        = r_updatePc;
   assign bus.actual_taken_o     = r_actualTaken;
   assign bus.actual_target_o    = r_actualTarget;
   assign bus.mispredict_o       = r_mispredict;
   assign bus.redirect_pc_o      = r_redirectPc;
   assign bus.underflow_o        = r_underflow;
   assign bus.branch_count_o     = r_branchCount;
   assign bus.mispredict_count_o = r_mispredictCount;
endmodule
